// File: rtl/async_sync_pkg.sv
// Shared types, limits and helpers for the multi-channel async synchronizer.
package async_sync_pkg;

  typedef enum logic {SYNC_LEVEL, SYNC_TOGGLE} sync_mode_e;

  localparam int SYNC_MIN_DEPTH = 2;

  // Counter wide enough to hold 0..filter_cycles.
  function automatic int filt_cnt_w(input int filter_cycles);
    return (filter_cycles < 1) ? 1 : $clog2(filter_cycles + 1);
  endfunction

endpackage

// File: rtl/async_sync_chain.sv
// Single-channel synchronizer: DEPTH-stage shift register with async reset to INIT_BIT.
module async_sync_chain #(
  parameter int   DEPTH    = 3,
  parameter logic INIT_BIT = 1'b0
) (
  input  logic clock,
  input  logic reset,
  input  logic din,
  output logic sync
);

  logic [DEPTH-1:0] stage;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      stage <= {DEPTH{INIT_BIT}};
    end else begin
      stage <= {stage[DEPTH-2:0], din};
    end
  end

  assign sync = stage[DEPTH-1];

endmodule

// File: rtl/async_valid_sync_array.sv
// N independent async-to-clock synchronizers with edge detect and level/toggle output.
// Optional per-channel debounce filter enabled by ASYNC_VALID_SYNC_FILTER_EN.
module async_valid_sync_array
  import async_sync_pkg::*;
#(
  parameter int           N             = 4,
  parameter int           DEPTH         = 3,
  parameter logic [N-1:0] INIT          = '0,
  parameter logic [N-1:0] MODE          = '0,
  parameter int           FILTER_CYCLES = 4
) (
  input  logic         clock,
  input  logic         reset,
  input  logic [N-1:0] io_in,
  output logic [N-1:0] io_out,
  output logic [N-1:0] io_rise,
  output logic [N-1:0] io_fall
);

  if (DEPTH < SYNC_MIN_DEPTH) begin : g_bad_depth
    $error("async_valid_sync_array: DEPTH must be >= %0d", SYNC_MIN_DEPTH);
  end
  if (N < 1) begin : g_bad_n
    $error("async_valid_sync_array: N must be >= 1");
  end
  if (FILTER_CYCLES < 1) begin : g_bad_filter
    $error("async_valid_sync_array: FILTER_CYCLES must be >= 1");
  end

  logic [N-1:0] sync;
  logic [N-1:0] lvl;
  logic [N-1:0] prev;

  for (genvar i = 0; i < N; i++) begin : g_ch
    localparam sync_mode_e CH_MODE = sync_mode_e'(MODE[i]);

    async_sync_chain #(
      .DEPTH    (DEPTH),
      .INIT_BIT (INIT[i])
    ) u_chain (
      .clock (clock),
      .reset (reset),
      .din   (io_in[i]),
      .sync  (sync[i])
    );

`ifdef ASYNC_VALID_SYNC_FILTER_EN
    localparam int CW = filt_cnt_w(FILTER_CYCLES);
    logic [CW-1:0] cnt;
    logic          lvl_q;

    // lvl follows sync only after it has disagreed for FILTER_CYCLES consecutive cycles.
    always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
        cnt   <= '0;
        lvl_q <= INIT[i];
      end else if (sync[i] == lvl_q) begin
        cnt <= '0;
      end else if (cnt == CW'(FILTER_CYCLES - 1)) begin
        lvl_q <= sync[i];
        cnt   <= '0;
      end else begin
        cnt <= cnt + CW'(1);
      end
    end

    assign lvl[i] = lvl_q;
`else
    assign lvl[i] = sync[i];
`endif

    logic prev_q;

    always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
        prev_q <= INIT[i];
      end else begin
        prev_q <= lvl[i];
      end
    end

    assign prev[i]    = prev_q;
    assign io_rise[i] = lvl[i] & ~prev[i];
    assign io_fall[i] = ~lvl[i] & prev[i];

    // Toggle mode turns every settled level change into a one-cycle pulse.
    if (CH_MODE == SYNC_TOGGLE) begin : g_toggle
      assign io_out[i] = lvl[i] ^ prev[i];
    end else begin : g_level
      assign io_out[i] = lvl[i];
    end
  end

endmodule

// File: tb/tb_async_valid_sync_array.sv
// Directed self-checking bench for async_valid_sync_array (N=4, DEPTH=3, INIT=0100, MODE=1000).
module tb_async_valid_sync_array;

  logic       clock = 1'b0;
  logic       reset;
  logic [3:0] io_in;
  logic [3:0] io_out;
  logic [3:0] io_rise;
  logic [3:0] io_fall;

  int tests = 0;
  int fails = 0;

  always #5 clock = ~clock;

  async_valid_sync_array #(
    .N             (4),
    .DEPTH         (3),
    .INIT          (4'b0100),
    .MODE          (4'b1000),
    .FILTER_CYCLES (4)
  ) dut (
    .clock   (clock),
    .reset   (reset),
    .io_in   (io_in),
    .io_out  (io_out),
    .io_rise (io_rise),
    .io_fall (io_fall)
  );

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic apply_reset(input logic [3:0] din);
    reset = 1'b1;
    io_in = din;
    repeat (3) tick();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    io_in = 4'b1111;
    for (int c = 0; c < 5; c++) begin
      tick();
      tests++;
      if (io_out !== 4'b0100 || io_rise !== 4'b0000 || io_fall !== 4'b0000) begin
        fails++;
        $display("FAIL reset_hold cyc%0d: out=%b rise=%b fall=%b, want out=0100 rise=0000 fall=0000",
                 c, io_out, io_rise, io_fall);
      end
    end
    reset = 1'b0;
    for (int c = 1; c <= 2; c++) begin
      tick();
      tests++;
      if (io_out !== 4'b0100 || io_rise !== 4'b0000) begin
        fails++;
        $display("FAIL reset_release_edge%0d: out=%b rise=%b, want out=0100 rise=0000", c, io_out, io_rise);
      end
    end
    // Third edge: levels arrive; ch3 (toggle mode) pulses on its 0->1 change.
    tick();
    tests++;
    if (io_out !== 4'b1111 || io_rise !== 4'b1011 || io_fall !== 4'b0000) begin
      fails++;
      $display("FAIL reset_release_edge3: out=%b rise=%b fall=%b, want out=1111 rise=1011 fall=0000",
               io_out, io_rise, io_fall);
    end
    tick();
    tests++;
    if (io_out !== 4'b0111 || io_rise !== 4'b0000) begin
      fails++;
      $display("FAIL reset_release_edge4: out=%b rise=%b, want out=0111 rise=0000", io_out, io_rise);
    end
  endtask

  task automatic test_level_latency();
    apply_reset(4'b0000);
    repeat (6) tick();
    io_in = 4'b0001;
    tick();
    tick();
    tests++;
    if (io_out[0] !== 1'b0 || io_rise[0] !== 1'b0) begin
      fails++;
      $display("FAIL latency_edge2: out0=%b rise0=%b, want 0 0", io_out[0], io_rise[0]);
    end
    tick();
    tests++;
    if (io_out !== 4'b0001 || io_rise !== 4'b0001) begin
      fails++;
      $display("FAIL latency_edge3: out=%b rise=%b, want out=0001 rise=0001", io_out, io_rise);
    end
    tick();
    tests++;
    if (io_out !== 4'b0001 || io_rise !== 4'b0000) begin
      fails++;
      $display("FAIL latency_edge4: out=%b rise=%b, want out=0001 rise=0000", io_out, io_rise);
    end
  endtask

  task automatic test_toggle();
    int npulse = 0;
    int p1 = -1;
    int p2 = -1;
    logic r1 = 1'b0;
    logic f2 = 1'b0;
    apply_reset(4'b0000);
    repeat (6) tick();
    io_in[3] = 1'b1;
    for (int i = 1; i <= 20; i++) begin
      tick();
      if (io_out[3]) begin
        npulse++;
        if (npulse == 1) begin
          p1 = i;
          r1 = io_rise[3];
        end else if (npulse == 2) begin
          p2 = i;
          f2 = io_fall[3];
        end
      end
      if (i == 8) io_in[3] = 1'b0;
    end
    tests++;
    if (npulse != 2) begin
      fails++;
      $display("FAIL toggle_count: pulses=%0d, want 2", npulse);
    end
    tests++;
    if (p1 != 3 || p2 != 11) begin
      fails++;
      $display("FAIL toggle_timing: pulses at %0d,%0d, want 3,11", p1, p2);
    end
    tests++;
    if (r1 !== 1'b1 || f2 !== 1'b1) begin
      fails++;
      $display("FAIL toggle_edges: rise_at_p1=%b fall_at_p2=%b, want 1 1", r1, f2);
    end
  endtask

  task automatic test_simultaneous();
    apply_reset(4'b0000);
    io_in = 4'b1011;
    tick();
    tick();
    tests++;
    if (io_rise !== 4'b0000 || io_fall !== 4'b0000) begin
      fails++;
      $display("FAIL simul_edge2: rise=%b fall=%b, want 0000 0000", io_rise, io_fall);
    end
    tick();
    tests++;
    if (io_rise !== 4'b1011 || io_fall !== 4'b0100 || io_out !== 4'b1011) begin
      fails++;
      $display("FAIL simul_edge3: rise=%b fall=%b out=%b, want rise=1011 fall=0100 out=1011",
               io_rise, io_fall, io_out);
    end
    tick();
    tests++;
    if (io_rise !== 4'b0000 || io_fall !== 4'b0000 || io_out !== 4'b0011) begin
      fails++;
      $display("FAIL simul_edge4: rise=%b fall=%b out=%b, want rise=0000 fall=0000 out=0011",
               io_rise, io_fall, io_out);
    end
  endtask

  task automatic test_reset_midflight();
    logic seen = 1'b0;
    apply_reset(4'b0000);
    repeat (6) tick();
    io_in[1] = 1'b1;
    tick();
    reset = 1'b1;
    io_in = 4'b0000;
    tick();
    tests++;
    if (io_out !== 4'b0100 || io_rise !== 4'b0000) begin
      fails++;
      $display("FAIL midflight_in_reset: out=%b rise=%b, want out=0100 rise=0000", io_out, io_rise);
    end
    tick();
    reset = 1'b0;
    for (int i = 0; i < 8; i++) begin
      tick();
      if (io_rise[1] || io_out[1]) seen = 1'b1;
    end
    tests++;
    if (seen !== 1'b0) begin
      fails++;
      $display("FAIL midflight_ch1: rise/out on ch1 seen=%b, want 0", seen);
    end
    tests++;
    if (io_out !== 4'b0000) begin
      fails++;
      $display("FAIL midflight_final: out=%b, want 0000", io_out);
    end
  endtask

  task automatic test_filter();
    logic seen = 1'b0;
    int   rise_at = 0;
    logic exp_seen;
    int   exp_rise;
`ifdef ASYNC_VALID_SYNC_FILTER_EN
    exp_seen = 1'b0;
    exp_rise = 7;
`else
    exp_seen = 1'b1;
    exp_rise = 3;
`endif
    apply_reset(4'b0000);
    repeat (6) tick();
    io_in = 4'b0001;
    tick();
    tick();
    io_in = 4'b0000;
    for (int i = 0; i < 12; i++) begin
      tick();
      if (io_out[0]) seen = 1'b1;
    end
    tests++;
    if (seen !== exp_seen) begin
      fails++;
      $display("FAIL filter_glitch: out0 seen=%b, want %b", seen, exp_seen);
    end
    io_in = 4'b0001;
    for (int i = 1; i <= 15; i++) begin
      tick();
      if (io_rise[0] && rise_at == 0) rise_at = i;
      if (i == 6) io_in = 4'b0000;
    end
    tests++;
    if (rise_at != exp_rise) begin
      fails++;
      $display("FAIL filter_pulse_rise: rise0 at edge %0d, want %0d", rise_at, exp_rise);
    end
  endtask

  initial begin
    reset = 1'b1;
    io_in = 4'b0000;
    test_reset();
    test_level_latency();
    test_toggle();
    test_simultaneous();
    test_reset_midflight();
    test_filter();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
